// File: rtl/lab3_pkg.sv
// Shared constants and width helpers for the scan decoder.
package lab3_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Prescaler counter width: enough bits to hold DIV-1, never fewer than one.
  function automatic int presc_width(input int div);
    if (div <= 2) return 1;
    return $clog2(div);
  endfunction

endpackage

// File: rtl/lab3_tick_gen.sv
// Scan prescaler: a count that wraps every DIV enabled cycles.
// tick flags the last count of the period; the parent decides whether it is consumed.
module lab3_tick_gen
  import lab3_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int            W    = presc_width(DIV);
  localparam logic [W-1:0]  LAST = W'(DIV - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign tick = (count_q == LAST);

  // Next count: clear wins, otherwise advance and roll over while running, else hold.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (run) begin
      count_d = tick ? '0 : count_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/lab3_scan_decoder.sv
// N-to-2^N one-hot select driver with direct and auto-scan modes.
// Dout is decoded from the next index so it always matches sel on the same edge.
module lab3_scan_decoder
  import lab3_pkg::*;
#(
  parameter int N          = 2,
  parameter int DIV        = 4,
  parameter int ACTIVE_LOW = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              mode,
  input  logic [N-1:0]      A,
  output logic [(2**N)-1:0] Dout,
  output logic [N-1:0]      sel,
  output logic              wrap
);

  localparam int               OUTS     = 2 ** N;
  localparam logic [N-1:0]     LAST_IDX = N'(OUTS - 1);
  localparam logic [OUTS-1:0]  INACTIVE = (ACTIVE_LOW != 0) ? {OUTS{1'b1}} : {OUTS{1'b0}};

  logic            scan_run;
  logic            dir_load;
  logic            tick;
  logic            scan_step;

  logic [N-1:0]    index_q, index_d;
  logic [OUTS-1:0] dout_q, dout_d;
  logic            wrap_q, wrap_d;

  assign scan_run  = enable && (mode == MODE_SCAN);
  assign dir_load  = enable && (mode == MODE_DIRECT);
  assign scan_step = scan_run && tick;

  lab3_tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .run   (scan_run),
    .clear (dir_load),
    .tick  (tick)
  );

  // Index selection: load A in direct mode, step on prescaler tick in scan mode, hold when disabled.
  always_comb begin
    index_d = index_q;
    if (dir_load) begin
      index_d = A;
    end else if (scan_step) begin
      index_d = index_q + N'(1);
    end
  end

  // Output decode of the next index, and the wrap pulse on OUTS-1 -> 0.
  always_comb begin
    dout_d = INACTIVE;
    if (enable) begin
      dout_d          = '0;
      dout_d[index_d] = 1'b1;
      dout_d          = dout_d ^ INACTIVE;
    end
    wrap_d = scan_step && (index_q == LAST_IDX);
  end

  // Index, select and wrap registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      index_q <= '0;
      dout_q  <= INACTIVE;
      wrap_q  <= 1'b0;
    end else begin
      index_q <= index_d;
      dout_q  <= dout_d;
      wrap_q  <= wrap_d;
    end
  end

  assign Dout = dout_q;
  assign sel  = index_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_lab3_scan_decoder.sv
// Self-checking bench: default instance (N=2, DIV=4, active-high) and a
// variant (N=3, DIV=1, active-low) compared against a behavioural model.
module tb_lab3_scan_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       en = 1'b0, md = 1'b0;
  logic [1:0] a = '0;
  logic [3:0] dout;
  logic [1:0] sel;
  logic       wrap;

  logic       en3 = 1'b0, md3 = 1'b0;
  logic [2:0] a3 = '0;
  logic [7:0] dout3;
  logic [2:0] sel3;
  logic       wrap3;

  int checks = 0;
  int errors = 0;

  // model state: index, prescaler count, expected Dout, expected wrap
  int m_idx = 0, m_pre = 0, m_dout = 0, m_wrap = 0;
  int m3_idx = 0, m3_pre = 0, m3_dout = 255, m3_wrap = 0;

  always #5 clk = ~clk;

  lab3_scan_decoder #(.N(2), .DIV(4), .ACTIVE_LOW(0)) dut (
    .clk(clk), .rst(rst), .enable(en), .mode(md), .A(a),
    .Dout(dout), .sel(sel), .wrap(wrap)
  );

  lab3_scan_decoder #(.N(3), .DIV(1), .ACTIVE_LOW(1)) dut3 (
    .clk(clk), .rst(rst), .enable(en3), .mode(md3), .A(a3),
    .Dout(dout3), .sel(sel3), .wrap(wrap3)
  );

  task automatic model_step(input int n, input int div, input int al,
                            input logic e, input logic m, input int av,
                            inout int idx, inout int pre, inout int dv, inout int wr);
    int outs;
    int mask;
    outs = 1 << n;
    mask = (1 << outs) - 1;
    if (!e) begin
      dv = al ? mask : 0;
      wr = 0;
    end else begin
      if (!m) begin
        idx = av; pre = 0; wr = 0;
      end else if (pre == div - 1) begin
        wr  = (idx == outs - 1) ? 1 : 0;
        idx = (idx + 1) % outs;
        pre = 0;
      end else begin
        pre = pre + 1;
        wr  = 0;
      end
      dv = al ? (mask & ~(1 << idx)) : (1 << idx);
    end
  endtask

  task automatic model_reset();
    m_idx = 0;  m_pre = 0;  m_dout = 0;    m_wrap = 0;
    m3_idx = 0; m3_pre = 0; m3_dout = 255; m3_wrap = 0;
  endtask

  // one clock edge: advance both models with the inputs seen at the edge, then sample point
  task automatic cycle();
    @(posedge clk);
    model_step(2, 4, 0, en, md, int'(a), m_idx, m_pre, m_dout, m_wrap);
    model_step(3, 1, 1, en3, md3, int'(a3), m3_idx, m3_pre, m3_dout, m3_wrap);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (dout !== 4'h0 || sel !== 2'd0 || wrap !== 1'b0) begin
      errors++; $display("FAIL reset_state: Dout=%b sel=%b wrap=%b, want 0000/00/0", dout, sel, wrap);
    end
    checks++;
    if (dout3 !== 8'hFF || sel3 !== 3'd0 || wrap3 !== 1'b0) begin
      errors++; $display("FAIL reset_state_al: Dout=%b sel=%b wrap=%b, want 11111111/000/0", dout3, sel3, wrap3);
    end
    en = 1'b1; md = 1'b0; a = 2'd2;
    cycle();
    checks++;
    if (dout !== 4'b0100) begin
      errors++; $display("FAIL reset_pre: Dout=%b want 0100", dout);
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if (dout !== 4'b0000 || sel !== 2'd0 || wrap !== 1'b0) begin
      errors++; $display("FAIL reset_async: Dout=%b sel=%b wrap=%b, want 0000/00/0", dout, sel, wrap);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_direct();
    en = 1'b1; md = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = 2'(i);
      cycle();
      checks++;
      if (dout !== 4'(1 << i) || sel !== 2'(i) || wrap !== 1'b0) begin
        errors++; $display("FAIL direct_%0d: Dout=%b sel=%b wrap=%b, want %b/%b/0", i, dout, sel, wrap, 4'(1 << i), 2'(i));
      end
    end
  endtask

  task automatic test_enable_gating();
    en = 1'b1; md = 1'b0; a = 2'd2;
    cycle();
    en = 1'b0; a = 2'd1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (dout !== 4'b0000 || sel !== 2'd2) begin
        errors++; $display("FAIL gate_hold_%0d: Dout=%b sel=%b, want 0000/10", i, dout, sel);
      end
    end
    en = 1'b1;
    cycle();
    checks++;
    if (dout !== 4'b0010 || sel !== 2'd1) begin
      errors++; $display("FAIL gate_reenable: Dout=%b sel=%b, want 0010/01", dout, sel);
    end
  endtask

  task automatic test_scan();
    logic [3:0] exp_d [12];
    int wraps;
    wraps = 0;
    for (int i = 0; i < 12; i++) exp_d[i] = (i < 4) ? 4'b0100 : (i < 8) ? 4'b1000 : 4'b0001;
    en = 1'b1; md = 1'b0; a = 2'd2;
    for (int i = 0; i < 12; i++) begin
      cycle();
      md = 1'b1;
      if (wrap === 1'b1) wraps++;
      checks++;
      if (dout !== exp_d[i] || dout !== 4'(m_dout) || wrap !== 1'(m_wrap)) begin
        errors++; $display("FAIL scan_%0d: Dout=%b wrap=%b, want %b/%0d", i, dout, wrap, exp_d[i], m_wrap);
      end
    end
    checks++;
    if (wraps !== 1) begin
      errors++; $display("FAIL scan_wrap_count: saw %0d wrap pulses, want 1", wraps);
    end
  endtask

  task automatic test_scan_freeze();
    en = 1'b1; md = 1'b0; a = 2'd0;
    cycle();
    md = 1'b1;
    cycle(); cycle();
    en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      checks++;
      if (dout !== 4'b0000 || sel !== 2'd0 || wrap !== 1'b0) begin
        errors++; $display("FAIL freeze_%0d: Dout=%b sel=%b wrap=%b, want 0000/00/0", i, dout, sel, wrap);
      end
    end
    en = 1'b1;
    cycle();
    checks++;
    if (sel !== 2'd0 || dout !== 4'b0001) begin
      errors++; $display("FAIL freeze_resume1: sel=%b Dout=%b, want 00/0001", sel, dout);
    end
    cycle();
    checks++;
    if (sel !== 2'd1 || dout !== 4'b0010) begin
      errors++; $display("FAIL freeze_resume2: sel=%b Dout=%b, want 01/0010", sel, dout);
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if (sel !== 2'd0 || dout !== 4'b0000 || wrap !== 1'b0) begin
      errors++; $display("FAIL scan_reset: sel=%b Dout=%b wrap=%b, want 00/0000/0", sel, dout, wrap);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_variant();
    logic [2:0] exp_s [4];
    logic       exp_w [4];
    exp_s[0] = 3'd6; exp_s[1] = 3'd7; exp_s[2] = 3'd0; exp_s[3] = 3'd1;
    exp_w[0] = 1'b0; exp_w[1] = 1'b0; exp_w[2] = 1'b1; exp_w[3] = 1'b0;
    en = 1'b0;
    en3 = 1'b1; md3 = 1'b0; a3 = 3'd5;
    cycle();
    checks++;
    if (dout3 !== 8'hDF || sel3 !== 3'd5) begin
      errors++; $display("FAIL variant_direct: Dout=%b sel=%b, want 11011111/101", dout3, sel3);
    end
    md3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      checks++;
      if (sel3 !== exp_s[i] || wrap3 !== exp_w[i] || dout3 !== ~(8'd1 << exp_s[i])) begin
        errors++; $display("FAIL variant_scan_%0d: sel=%b wrap=%b Dout=%b, want %b/%b", i, sel3, wrap3, dout3, exp_s[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      en  = ($urandom_range(0, 9) < 8);
      md  = ($urandom_range(0, 9) < 6);
      a   = 2'($urandom);
      en3 = ($urandom_range(0, 9) < 8);
      md3 = ($urandom_range(0, 9) < 6);
      a3  = 3'($urandom);
      cycle();
      checks++;
      if (dout !== 4'(m_dout) || sel !== 2'(m_idx) || wrap !== 1'(m_wrap)) begin
        errors++; $display("FAIL random_%0d: Dout=%b sel=%b wrap=%b, want %b/%b/%0d", i, dout, sel, wrap, 4'(m_dout), 2'(m_idx), m_wrap);
      end
      checks++;
      if (dout3 !== 8'(m3_dout) || sel3 !== 3'(m3_idx) || wrap3 !== 1'(m3_wrap)) begin
        errors++; $display("FAIL random3_%0d: Dout=%b sel=%b wrap=%b, want %b/%b/%0d", i, dout3, sel3, wrap3, 8'(m3_dout), 3'(m3_idx), m3_wrap);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    test_reset();
    test_direct();
    test_enable_gating();
    test_scan();
    test_scan_freeze();
    test_variant();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
